// File: rtl/cpu_sqrt_core.sv
// Integer square root by odd-number subtraction: ANS0 = floor(sqrt(number)), ANS1 = remainder.
// Define CPU_LIVE_EN to make ANS0/ANS1 follow the running count and residue every RUN cycle.
module cpu_sqrt_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] number,
  output logic [WIDTH-1:0] ANS0,
  output logic [WIDTH-1:0] ANS1
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] num_q, num_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] odd_q, odd_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] ans0_q, ans0_d;
  logic [WIDTH-1:0] ans1_q, ans1_d;
  logic             load;

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    r_d     = r_q;
    odd_d   = odd_q;
    cnt_d   = cnt_q;
    ans0_d  = ans0_q;
    ans1_d  = ans1_q;
    load    = 1'b0;

    if (en) begin
      unique case (state_q)
        StIdle: load = 1'b1;
        StRun: begin
          // Compare before subtract so r never wraps.
          if (r_q >= odd_q) begin
            r_d   = r_q - odd_q;
            odd_d = odd_q + WIDTH'(2);
            cnt_d = cnt_q + WIDTH'(1);
`ifdef CPU_LIVE_EN
            ans0_d = cnt_q + WIDTH'(1);
            ans1_d = r_q - odd_q;
`endif
          end else begin
            ans0_d  = cnt_q;
            ans1_d  = r_q;
            state_d = StDone;
          end
        end
        StDone: load = (number != num_q);
        default: state_d = StIdle;
      endcase
    end

    if (load) begin
      num_d   = number;
      r_d     = number;
      odd_d   = WIDTH'(1);
      cnt_d   = '0;
      state_d = StRun;
`ifdef CPU_LIVE_EN
      ans0_d = '0;
      ans1_d = number;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      num_q   <= '0;
      r_q     <= '0;
      odd_q   <= WIDTH'(1);
      cnt_q   <= '0;
      ans0_q  <= '0;
      ans1_q  <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      r_q     <= r_d;
      odd_q   <= odd_d;
      cnt_q   <= cnt_d;
      ans0_q  <= ans0_d;
      ans1_q  <= ans1_d;
    end
  end

  assign ANS0 = ans0_q;
  assign ANS1 = ans1_q;

endmodule

// File: tb/tb_cpu_sqrt_core.sv
// Directed bench for cpu_sqrt_core: vector table with exact latency, plus freeze/reload/reset sequences.
module tb_cpu_sqrt_core;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] number;
  logic [31:0] ans0;
  logic [31:0] ans1;

  int n_checks;
  int n_fail;

  cpu_sqrt_core #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .number (number),
    .ANS0   (ans0),
    .ANS1   (ans1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] num;
    logic [31:0] a0;
    logic [31:0] a1;
    int          edges;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] e0, input logic [31:0] e1);
    n_checks++;
    if (ans0 !== e0 || ans1 !== e1) begin
      n_fail++;
      $display("FAIL %s: got ANS0=%0d ANS1=%0d, expected ANS0=%0d ANS1=%0d",
               name, ans0, ans1, e0, e1);
    end
  endtask

  // Advance n rising edges; returns 1 time unit after the last edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    en       = 1'b0;
    number   = 32'd0;

    vecs[0] = '{num: 32'd10,         a0: 32'd3,     a1: 32'd1,      edges: 5};
    vecs[1] = '{num: 32'd0,          a0: 32'd0,     a1: 32'd0,      edges: 2};
    vecs[2] = '{num: 32'd1,          a0: 32'd1,     a1: 32'd0,      edges: 3};
    vecs[3] = '{num: 32'd4,          a0: 32'd2,     a1: 32'd0,      edges: 4};
    vecs[4] = '{num: 32'd15,         a0: 32'd3,     a1: 32'd6,      edges: 5};
    vecs[5] = '{num: 32'd16,         a0: 32'd4,     a1: 32'd0,      edges: 6};
    vecs[6] = '{num: 32'd8191,       a0: 32'd90,    a1: 32'd91,     edges: 92};
    vecs[7] = '{num: 32'hFFFF_FFFF,  a0: 32'd65535, a1: 32'd131070, edges: 65537};

    #3;
    do_reset();
    check("reset_state", 32'd0, 32'd0);

    // en low in IDLE: nothing happens.
    number = 32'd10;
    step(5);
    check("idle_frozen", 32'd0, 32'd0);

    for (int v = 0; v < 8; v++) begin
      do_reset();
      number = vecs[v].num;
      en     = 1'b1;
      step(vecs[v].edges - 1);
`ifndef CPU_LIVE_EN
      check($sformatf("vec%0d_before", v), 32'd0, 32'd0);
`endif
      step(1);
      check($sformatf("vec%0d_result", v), vecs[v].a0, vecs[v].a1);
    end

    // DONE with unchanged operand stays put; async reset clears without an edge.
    do_reset();
    number = 32'd10;
    en     = 1'b1;
    step(5);
    step(5);
    check("done_stable", 32'd3, 32'd1);
    rst = 1'b0;
    #1;
    check("async_reset", 32'd0, 32'd0);
    #1;
    rst = 1'b1;

    // Reset mid-run, then restart.
    step(5);
    check("pre_midrun", 32'd3, 32'd1);
    number = 32'd8191;
    step(40);
`ifndef CPU_LIVE_EN
    check("midrun_hold_old", 32'd3, 32'd1);
`endif
    rst = 1'b0;
    #1;
    check("midrun_reset", 32'd0, 32'd0);
    #1;
    rst = 1'b1;
    step(91);
`ifndef CPU_LIVE_EN
    check("restart_before", 32'd0, 32'd0);
`endif
    step(1);
    check("restart_result", 32'd90, 32'd91);

    // Freeze mid-run for 10 cycles; a number change during RUN takes effect only from DONE.
    do_reset();
    number = 32'd100;
    en     = 1'b1;
    step(5);
    en = 1'b0;
    step(10);
    number = 32'd17;
    en     = 1'b1;
    step(6);
`ifndef CPU_LIVE_EN
    check("freeze_before", 32'd0, 32'd0);
`endif
    step(1);
    check("freeze_result", 32'd10, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      step(1);
`ifndef CPU_LIVE_EN
      check($sformatf("reload_hold%0d", i), 32'd10, 32'd0);
`endif
    end
    step(1);
    check("reload_result", 32'd4, 32'd1);

    // en low in DONE with a new operand: no reload.
    en     = 1'b0;
    number = 32'd10;
    step(8);
    check("done_frozen", 32'd4, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
